// File: rtl/fifo_dispatcher_if.sv
// Handshake bundle between a FIFO, the pair dispatcher and the downstream MAC.
// The master side is the dispatcher itself; the slave side is its environment.
interface fifo_dispatcher_if #(
  parameter int DataWidth  = 32,
  parameter int BufferSize = 4,
  parameter int CountWidth = 16
);
  logic                  Empty;
  logic [BufferSize-1:0] ReadyM;
  logic [DataWidth-1:0]  DataOut1;
  logic [DataWidth-1:0]  DataOut2;
  logic                  Flush;
  logic                  Pop1;
  logic                  Pop2;
  logic [DataWidth-1:0]  OpA;
  logic [DataWidth-1:0]  OpB;
  logic                  OutValid;
  logic                  OutReady;
  logic                  Last;
  logic                  Done;
  logic [CountWidth-1:0] PairCount;

  modport master (
    input  Empty, ReadyM, DataOut1, DataOut2, Flush, OutReady,
    output Pop1, Pop2, OpA, OpB, OutValid, Last, Done, PairCount
  );

  modport slave (
    output Empty, ReadyM, DataOut1, DataOut2, Flush, OutReady,
    input  Pop1, Pop2, OpA, OpB, OutValid, Last, Done, PairCount
  );
endinterface

// File: rtl/fifo_dispatcher.sv
// Pulls operand pairs off the head of a FIFO and presents them to a MAC through
// a one-deep output register; a lone trailing entry is padded with zero on Flush.
module fifo_dispatcher #(
  parameter int DataWidth  = 32,
  parameter int BufferSize = 4,
  parameter int CountWidth = 16
) (
  input logic               clk,
  input logic               rst,
  fifo_dispatcher_if.master bus
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t                state;
  logic [DataWidth-1:0]  op_a;
  logic [DataWidth-1:0]  op_b;
  logic                  out_valid;
  logic                  last;
  logic                  done;
  logic                  done_armed;
  logic [CountWidth-1:0] pair_count;

  logic idle;
  logic take_pair;
  logic take_single;
  logic drained;
  logic ready_unused;

  // Empty dominates ReadyM so that inconsistent status never causes a pop.
  always_comb begin
    idle        = (state == IDLE) && !rst;
    take_pair   = idle && !bus.Empty && (bus.ReadyM[1:0] == 2'b11);
    take_single = idle && !bus.Empty && bus.Flush && (bus.ReadyM[1:0] == 2'b01);
    drained     = idle && bus.Flush && bus.Empty;
  end

  assign ready_unused = ^bus.ReadyM;

  assign bus.Pop1      = take_single;
  assign bus.Pop2      = take_pair;
  assign bus.OpA       = op_a;
  assign bus.OpB       = op_b;
  assign bus.OutValid  = out_valid;
  assign bus.Last      = last;
  assign bus.Done      = done;
  assign bus.PairCount = pair_count;

  // done_armed keeps a held Flush on an empty FIFO from pulsing Done repeatedly;
  // it re-arms when Flush drops or when new data is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      out_valid  <= 1'b0;
      last       <= 1'b0;
      done       <= 1'b0;
      done_armed <= 1'b1;
      pair_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.Flush) begin
            done_armed <= 1'b1;
          end
          if (take_pair) begin
            op_a       <= bus.DataOut1;
            op_b       <= bus.DataOut2;
            last       <= 1'b0;
            out_valid  <= 1'b1;
            done_armed <= 1'b1;
            state      <= HOLD;
          end else if (take_single) begin
            op_a       <= bus.DataOut1;
            op_b       <= '0;
            last       <= 1'b1;
            out_valid  <= 1'b1;
            done_armed <= 1'b1;
            state      <= HOLD;
          end else if (drained && done_armed) begin
            done       <= 1'b1;
            done_armed <= 1'b0;
          end
        end
        HOLD: begin
          if (bus.OutReady) begin
            out_valid  <= 1'b0;
            pair_count <= pair_count + 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
